// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
package div_pkg;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage : div_pkg

// File: rtl/radix2_div_engine.sv
// Multicycle restoring radix-2 divider for MIPS32 DIV/DIVU, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |divisor| > |dividend|.
module radix2_div_engine
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_div,
    input  logic             op_divu,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             stall
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
`ifdef DIV_EARLY_OUT_EN
    logic             early_q, early_d;
`endif

    logic             start_s;
    logic             signed_s;
    logic [WIDTH-1:0] dd_mag_s;
    logic [WIDTH-1:0] dv_mag_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   trial_s;

    assign start_s  = op_div | op_divu;
    assign signed_s = op_div;
    assign dd_mag_s = (signed_s && dividend[WIDTH-1]) ? (~dividend + ONE) : dividend;
    assign dv_mag_s = (signed_s && divisor[WIDTH-1])  ? (~divisor + ONE)  : divisor;

    // The trial MSB is the borrow: it is set exactly when rem_sh < divisor.
    assign rem_sh_s = {rem_q, q_q[WIDTH-1]};
    assign trial_s  = rem_sh_s - {1'b0, dvs_q};

    // Next-state and datapath update for the start and iterate phases.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`ifdef DIV_EARLY_OUT_EN
        early_d   = early_q;
`endif
        case (state_q)
            DIV_IDLE: begin
                if (start_s) begin
                    state_d   = DIV_RUN;
                    cnt_d     = CNT_W'(WIDTH);
                    q_d       = dd_mag_s;
                    rem_d     = {WIDTH{1'b0}};
                    dvs_d     = dv_mag_s;
                    // A zero divisor leaves the all-ones quotient unsigned.
                    neg_quo_d = signed_s & (dividend[WIDTH-1] ^ divisor[WIDTH-1])
                                & (divisor != {WIDTH{1'b0}});
                    neg_rem_d = signed_s & dividend[WIDTH-1];
`ifdef DIV_EARLY_OUT_EN
                    early_d   = 1'b0;
                    if (dv_mag_s > dd_mag_s) begin
                        cnt_d   = CNT_W'(1);
                        q_d     = {WIDTH{1'b0}};
                        rem_d   = dd_mag_s;
                        early_d = 1'b1;
                    end else begin
                        early_d = 1'b0;
                    end
`endif
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_RUN: begin
`ifdef DIV_EARLY_OUT_EN
                if (!early_q) begin
`else
                begin
`endif
                    if (trial_s[WIDTH]) begin
                        rem_d = rem_sh_s[WIDTH-1:0];
                        q_d   = {q_q[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_d = trial_s[WIDTH-1:0];
                        q_d   = {q_q[WIDTH-2:0], 1'b1};
                    end
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d = DIV_RUN;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            q_q       <= {WIDTH{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            dvs_q     <= {WIDTH{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            early_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`ifdef DIV_EARLY_OUT_EN
            early_q   <= early_d;
`endif
        end
    end

    assign stall     = (state_q == DIV_RUN);
    assign quotient  = neg_quo_q ? (~q_q + ONE) : q_q;
    assign remainder = neg_rem_q ? (~rem_q + ONE) : rem_q;

endmodule : radix2_div_engine
